// File: rtl/regfile_write_port.sv
// rtl/regfile_write_port.sv - write side of the 32x32 register file
// Buffers write-back requests in a small in-order FIFO and commits one per cycle.
module regfile_write_port #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4:0]            wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  hold,
  input  logic [4:0]            chk_addr,
  output logic                  chk_pending,
  output logic                  busy,
  output logic [32*WIDTH-1:0]   q_flat
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]    count;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [DEPTH-1:0] ent_valid;
  logic [4:0]       ent_addr [DEPTH];
  logic [WIDTH-1:0] ent_data [DEPTH];
  logic [WIDTH-1:0] regs [32];
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign wr_ready = (count < CW'(DEPTH));
  assign busy     = (count != '0);
  // Writes to r0 complete the handshake but never occupy a slot.
  assign push     = wr_valid && wr_ready && (wr_addr != 5'd0);
  assign pop      = busy && !hold;

  always_comb begin
    chk_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == chk_addr)) chk_pending = 1'b1;
    end
    if (chk_addr == 5'd0) chk_pending = 1'b0;
  end

  // A push never lands on the head slot being popped: push needs count < DEPTH,
  // and pop needs count > 0, so head != tail whenever both fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
      for (int r = 0; r < 32; r++) regs[r] <= '0;
    end else begin
      if (pop) begin
        if (ent_addr[head] != 5'd0) regs[ent_addr[head]] <= ent_data[head];
        ent_valid[head] <= 1'b0;
        head            <= ptr_inc(head);
      end
      if (push) begin
        ent_addr[tail]  <= wr_addr;
        ent_data[tail]  <= wr_data;
        ent_valid[tail] <= 1'b1;
        tail            <= ptr_inc(tail);
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  for (genvar g = 0; g < 32; g++) begin : g_flat
    assign q_flat[WIDTH*g +: WIDTH] = regs[g];
  end

endmodule

// File: doc/regfile_write_port.md
Name: regfile_write_port

Overview:
- Write side of the 32x32 CPU register file.
- Accepts write-back requests over a valid/ready handshake and buffers them in a small in-order FIFO.
- Commits one entry per cycle into the 32-entry register storage, with register 0 hardwired to zero.
- Exposes all 32 registers as a flat bus to the read-select muxes, plus a pending-write hazard check for the issue stage.

Parameters:
- DEPTH, 2, write-buffer entries; legal range 1 to 4.
- WIDTH, 32, register data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  buffer can accept a request.
- wr_addr  in  5  destination register number.
- wr_data  in  WIDTH  write data.
- hold  in  1  stall commit when 1; enqueue still allowed.
- chk_addr  in  5  register number to check for a pending write.
- chk_pending  out  1  a queued, uncommitted write targets chk_addr.
- busy  out  1  buffer non-empty.
- q_flat  out  32*WIDTH  register contents; bits [WIDTH*i+WIDTH-1 : WIDTH*i] hold register i.

Behaviour:
- Reset, asynchronous, immediate on rst=1:
  - all 32 registers = 0 and FIFO emptied (count=0, pointers=0);
  - wr_ready=1, busy=0, chk_pending=0.
  - Reset mid-operation discards all queued writes; nothing partially commits.
- Handshake:
  - A transfer occurs on a rising edge with wr_valid=1 and wr_ready=1.
  - wr_ready = (count < DEPTH), combinational from registered state only; it does not depend on wr_valid.
  - The requester may drop or change wr_valid/wr_addr/wr_data at any time while wr_ready=0.
- r0 filter: a transfer with wr_addr=0 completes the handshake but is NOT enqueued. count is unchanged and register 0 stays 0 forever.
- Commit:
  - On each rising edge with count>0 and hold=0, the head entry is written to register[head.addr] and popped.
  - Commit order equals acceptance order.
- Latency: a write accepted at edge N into an empty FIFO with hold=0 commits at edge N+1. It appears on q_flat after edge N+1, and chk_pending for its address is 1 during the cycle between edges N and N+1.
- Same-edge events:
  - Enqueue and commit on the same edge: count unchanged, both take effect.
  - When full (count=DEPTH), wr_ready=0, so no enqueue is possible. Commit on that edge frees a slot; wr_ready rises the following cycle (no same-cycle pass-through).
- Same address queued twice: both commit in order; the later value wins.
- chk_pending:
  - Combinational OR over valid FIFO entries of (entry.addr == chk_addr).
  - Forced 0 when chk_addr=0.
  - Does not include the in-flight wr_* request.
- busy = (count != 0).
- hold=1: no commit, FIFO contents frozen except for enqueue. Writes made while holding become visible in order once hold drops.
- Pointers wrap modulo DEPTH. count is ceil(log2(DEPTH+1)) bits and never exceeds DEPTH or underflows.
- q_flat is registered state only; there is no write-to-read bypass.

Test Plan:
- Reset then single write: rst pulse; write addr 5, data 0xDEADBEEF, hold=0 → chk_pending(5)=1 for one cycle; register 5 = 0xDEADBEEF on q_flat one edge after acceptance; busy returns 0.
- r0 discard: write addr 0, data 0xFFFFFFFF → handshake completes, busy stays 0, register 0 remains 0, chk_pending(0)=0.
- Full/backpressure: hold=1; write addr 1 = 0x11 and addr 2 = 0x22 → wr_ready=0; third request stalls. Release hold → 0x11 then 0x22 commit on consecutive edges; wr_ready returns to 1 the cycle after the first commit; third request then accepted.
- Same-address ordering: back-to-back writes to addr 7 of 0xA then 0xB → register 7 ends at 0xB; chk_pending(7)=1 until the second commit.
- Simultaneous enqueue/commit: streaming one write per cycle to addrs 1..31 with hold=0 → wr_ready never drops, count stays ≤1, and every register i holds its written value.
- Async reset mid-operation: two entries queued with hold=1; assert rst between edges → busy=0 and all registers=0 immediately; after release, neither queued write ever commits.
